mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: BUS_DATA_WIDTH, 64, width of one bus beat.
REQ-002 Parameter: BUS_TAG_WIDTH, 13, width of bus request/response tag.
REQ-003 Parameter: BEATS, 8, beats per 64-byte block transfer.
REQ-004 Reset is reset, synchronous, active-low; clock is clk.
REQ-005 clk  in  1  clock; all state changes on posedge.
REQ-006 reset  in  1  synchronous active-low reset.
REQ-007 i_req  in  1  instruction cache requests a block read; held until i_done.
REQ-008 i_addr  in  64  block-aligned instruction read address.
REQ-009 d_req  in  1  data cache requests a block read or writeback; held until d_done.
REQ-010 d_write  in  1  1 = writeback, 0 = read; sampled at grant.
REQ-011 d_addr  in  64  block-aligned data address.
REQ-012 d_wdata  in  64  current writeback beat; advanced by the data cache on d_wbeat_ack.
REQ-013 d_wbeat_ack  out  1  one-cycle pulse: current d_wdata beat accepted by bus.
REQ-014 i_rvalid / d_rvalid  out  1  one-cycle pulse: response beat valid for that requester.
REQ-015 i_rdata / d_rdata  out  64  response beat data; i_rbeat / d_rbeat out 3, beat index 0..BEATS-1.
REQ-016 i_done / d_done  out  1  one-cycle pulse: transaction complete.
REQ-017 bus_reqcyc out 1; bus_reqack in 1; bus_req out 64; bus_reqtag out 13: bus request channel.
REQ-018 bus_respcyc in 1; bus_respack out 1; bus_resp in 64; bus_resptag in 13: bus response channel.

Function
REQ-019 FSM states: IDLE, ADDR, WDATA, RESP, DONE.
REQ-020 IDLE: requests are sampled, owner is latched, and the FSM moves to ADDR on the next edge; only one transaction is outstanding at any time.
REQ-021 Arbitration when i_req and d_req are both high in IDLE: round-robin, granting the requester not granted last; last_grant resets to D, so I wins the first tie.
REQ-022 ADDR: bus_reqcyc=1, bus_req=latched address, bus_reqtag=MEM_READ or MEM_WRITE; outputs are held stable until bus_reqack.
REQ-023 On bus_reqack in ADDR: a read goes to RESP; a write goes to WDATA with beat counter 0.
REQ-024 WDATA: bus_reqcyc=1, bus_req=d_wdata; each bus_reqack pulses d_wbeat_ack and increments the counter; the ack of beat BEATS-1 goes to DONE.
REQ-025 RESP: bus_respack = bus_respcyc, combinationally; each accepted beat pulses the owner's *_rvalid with *_rdata=bus_resp and *_rbeat=counter, then increments the counter.
REQ-026 The response beat with counter BEATS-1 goes to DONE; bus_resptag is checked against MEM_READ, and a mismatching beat is still acked but not forwarded and not counted.
REQ-027 DONE: pulses the owner's *_done for exactly one cycle, updates last_grant, and returns to IDLE.
REQ-028 Beat counter is 3 bits and wraps to 0 at DONE; it never wraps mid-transaction.
REQ-029 A requester dropping its request mid-transaction does not abort the transaction; it completes and the done pulse is still issued.
REQ-030 Outside ADDR/WDATA bus_reqcyc=0 and bus_req/bus_reqtag=0; outside RESP bus_respack=0 and *_rvalid=0.
REQ-031 Response latency: the first *_rvalid appears in the same cycle as the first accepted bus_respcyc.
REQ-032 Grant latency: IDLE to ADDR takes one cycle after the request is sampled.

Reset
REQ-033 When reset=0: FSM goes to IDLE, counter=0, last_grant=D, and all outputs are 0 on the following edge.
REQ-034 Reset mid-transaction abandons the transaction silently with no done pulse; the bus master is responsible for draining in-flight responses.

Structure
REQ-035 The shared package holds BUS_DATA_WIDTH, BUS_TAG_WIDTH, ADDRESS_SIZE, MEM_READ, MEM_WRITE, BEATS and the arb_state_t enum.
REQ-036 Sub-module rr_arbiter2 is a 2-requester round-robin grant with a last_grant flop.
REQ-037 There are no other sub-modules.

Verification
REQ-038 i_req only, addr 0x1000, bus acks at cycle 3, then 8 resp beats 0..7 -> 8 i_rvalid pulses with i_rbeat 0..7, then i_done; d_* stays quiet.
REQ-039 i_req and d_req (read) asserted in the same cycle after reset -> I is served first, then D; a second simultaneous pair is served D first.
REQ-040 d_req with d_write=1, addr 0x2040, bus_reqack delayed 2 cycles per beat -> 8 d_wbeat_ack pulses, bus_req equals each d_wdata beat, one d_done, and no bus_respack.
REQ-041 During RESP of an I read, bus_respcyc stalls 5 cycles between beats 3 and 4 -> no rvalid during the stall and beat order is preserved.
REQ-042 Reset asserted after beat 2 of a D read -> next cycle all outputs are 0 and the FSM is IDLE; a new i_req is then granted normally.
REQ-043 Response beat carrying a tag other than MEM_READ -> bus_respack=1, no rvalid, and the beat counter is unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, bus tags and state/owner types for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 64;
    localparam int unsigned BUS_TAG_WIDTH  = 13;
    localparam int unsigned ADDRESS_SIZE   = 64;
    localparam int unsigned BEATS          = 8;

    localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h0001;
    localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0002;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RESP,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus request/response channels; the arbiter is the master side.
interface mem_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH = mem_bus_arbiter_pkg::BUS_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = mem_bus_arbiter_pkg::BUS_TAG_WIDTH
);

    logic                  bus_reqcyc;
    logic                  bus_reqack;
    logic [DATA_WIDTH-1:0] bus_req;
    logic [TAG_WIDTH-1:0]  bus_reqtag;
    logic                  bus_respcyc;
    logic                  bus_respack;
    logic [DATA_WIDTH-1:0] bus_resp;
    logic [TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; a tie goes to whoever was not served last.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   update,
    input  owner_t done_owner,
    output owner_t grant
);

    owner_t last_grant;

    // Remember who finished last; reset favours I on the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= OWNER_D;
        end else if (update) begin
            last_grant <= done_owner;
        end
    end

    // Grant the lone requester, or the one not served last on a tie.
    always_comb begin
        grant = OWNER_I;
        if (i_req && d_req) begin
            grant = (last_grant == OWNER_D) ? OWNER_I : OWNER_D;
        end else if (d_req) begin
            grant = OWNER_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one block-transfer memory bus between the instruction and data caches.
module mem_bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = mem_bus_arbiter_pkg::BUS_DATA_WIDTH,
    parameter int unsigned BUS_TAG_WIDTH  = mem_bus_arbiter_pkg::BUS_TAG_WIDTH,
    parameter int unsigned BEATS          = mem_bus_arbiter_pkg::BEATS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      i_req,
    input  logic [mem_bus_arbiter_pkg::ADDRESS_SIZE-1:0] i_addr,
    input  logic                                      d_req,
    input  logic                                      d_write,
    input  logic [mem_bus_arbiter_pkg::ADDRESS_SIZE-1:0] d_addr,
    input  logic [BUS_DATA_WIDTH-1:0]                 d_wdata,
    output logic                                      d_wbeat_ack,
    output logic                                      i_rvalid,
    output logic [BUS_DATA_WIDTH-1:0]                 i_rdata,
    output logic [$clog2(BEATS)-1:0]                  i_rbeat,
    output logic                                      d_rvalid,
    output logic [BUS_DATA_WIDTH-1:0]                 d_rdata,
    output logic [$clog2(BEATS)-1:0]                  d_rbeat,
    output logic                                      i_done,
    output logic                                      d_done,
    mem_bus_arbiter_if.master                         bus
);

    import mem_bus_arbiter_pkg::*;

    localparam int unsigned       CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t              state;
    arb_state_t              state_next;
    owner_t                  owner;
    owner_t                  grant;
    logic                    is_write;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [CNT_W-1:0]        cnt;
    logic                    resp_good;
    logic                    done_update;

    // A response beat only counts when it carries the read tag.
    assign resp_good   = bus.bus_respcyc && (bus.bus_resptag == BUS_TAG_WIDTH'(MEM_READ));
    assign done_update = (state == DONE);

    rr_arbiter2 u_rr_arbiter2 (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .d_req      (d_req),
        .update     (done_update),
        .done_owner (owner),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection for a single outstanding transaction.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req || d_req) state_next = ADDR;
            ADDR:    if (bus.bus_reqack) state_next = is_write ? WDATA : RESP;
            WDATA:   if (bus.bus_reqack && (cnt == LAST_BEAT)) state_next = DONE;
            RESP:    if (resp_good && (cnt == LAST_BEAT)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner at grant and track accepted beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner    <= OWNER_I;
            is_write <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner    <= grant;
                        is_write <= (grant == OWNER_D) && d_write;
                        addr     <= (grant == OWNER_D) ? d_addr : i_addr;
                    end
                end
                ADDR:    if (bus.bus_reqack) cnt <= '0;
                WDATA:   if (bus.bus_reqack) cnt <= cnt + 1'b1;
                RESP:    if (resp_good) cnt <= cnt + 1'b1;
                DONE:    cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    // Bus channel and requester-side outputs decoded from state.
    always_comb begin
        bus.bus_reqcyc  = 1'b0;
        bus.bus_req     = '0;
        bus.bus_reqtag  = '0;
        bus.bus_respack = 1'b0;
        d_wbeat_ack     = 1'b0;
        i_rvalid        = 1'b0;
        i_rdata         = '0;
        i_rbeat         = '0;
        d_rvalid        = 1'b0;
        d_rdata         = '0;
        d_rbeat         = '0;
        i_done          = 1'b0;
        d_done          = 1'b0;
        case (state)
            ADDR: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = BUS_DATA_WIDTH'(addr);
                bus.bus_reqtag = is_write ? BUS_TAG_WIDTH'(MEM_WRITE) : BUS_TAG_WIDTH'(MEM_READ);
            end
            WDATA: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = d_wdata;
                bus.bus_reqtag = BUS_TAG_WIDTH'(MEM_WRITE);
                d_wbeat_ack    = bus.bus_reqack;
            end
            RESP: begin
                bus.bus_respack = bus.bus_respcyc;
                if (resp_good) begin
                    if (owner == OWNER_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = bus.bus_resp;
                        d_rbeat  = cnt;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = bus.bus_resp;
                        i_rbeat  = cnt;
                    end
                end
            end
            DONE: begin
                i_done = (owner == OWNER_I);
                d_done = (owner == OWNER_D);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: the bench acts as both caches and as the memory slave.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        i_req, d_req, d_write;
    logic [63:0] i_addr, d_addr, d_wdata;
    logic        d_wbeat_ack, i_rvalid, d_rvalid, i_done, d_done;
    logic [63:0] i_rdata, d_rdata;
    logic [2:0]  i_rbeat, d_rbeat;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    bit          model_last_d = 1'b1;
    logic [63:0] wd [8];

    mem_bus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

    mem_bus_arbiter #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wbeat_ack(d_wbeat_ack),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rbeat(i_rbeat),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rbeat(d_rbeat),
        .i_done(i_done), .d_done(d_done),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "watchdog expired");
    end

    // Round-robin rule: lone requester wins; on a tie the one not served last wins.
    function automatic bit pick_d(input bit ri, input bit rd);
        if (ri && rd) return !model_last_d;
        return rd;
    endfunction

    function automatic logic [63:0] rnd_addr();
        return {$urandom, $urandom} & ~64'h3F;
    endfunction

    task automatic fill_wdata();
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        d_wdata = wd[0];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_req = 0; d_req = 0; d_write = 0;
        bus.bus_reqack = 0; bus.bus_respcyc = 0; bus.bus_resp = '0; bus.bus_resptag = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_last_d = 1'b1;
        @(negedge clk);
    endtask

    // Memory-slave side of one transaction; stops early after abort_after good beats.
    task automatic serve(input bit exp_d, input bit wr, input logic [63:0] addr,
                         input int unsigned ack_dly, input int unsigned stall_beat,
                         input int unsigned stall_len, input int unsigned bad_beat,
                         input int unsigned abort_after, input bit drop_early);
        logic [63:0] rd;
        int unsigned b, stalled, guard;
        bit bad_seen;
        b = 0; stalled = 0; guard = 0; bad_seen = 0;
        for (int k = 0; k < 20 && bus.bus_reqcyc !== 1'b1; k++) begin
            @(negedge clk); #1;
        end
        n_chk++;
        if (bus.bus_reqcyc !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_timeout: bus_reqcyc=%b required 1", bus.bus_reqcyc);
            return;
        end
        for (int unsigned k = 0; k <= ack_dly; k++) begin
            if (k != 0) begin @(negedge clk); #1; end
            n_chk++;
            if (bus.bus_reqcyc !== 1'b1 || bus.bus_req !== addr ||
                bus.bus_reqtag !== (wr ? MEM_WRITE : MEM_READ) || bus.bus_respack !== 1'b0) begin
                n_fail++;
                $display("FAIL addr_phase: reqcyc=%b req=%h tag=%h respack=%b required 1 %h %h 0",
                         bus.bus_reqcyc, bus.bus_req, bus.bus_reqtag, bus.bus_respack,
                         addr, wr ? MEM_WRITE : MEM_READ);
            end
            bus.bus_reqack = (k == ack_dly);
        end
        @(negedge clk);
        bus.bus_reqack = 0;
        if (drop_early) begin
            if (exp_d) begin d_req = 0; d_write = 1'($urandom); end
            else i_req = 0;
        end
        if (wr) begin
            for (int unsigned bb = 0; bb < 8; bb++) begin
                for (int unsigned k = 0; k <= ack_dly; k++) begin
                    d_wdata = wd[bb];
                    bus.bus_reqack = (k == ack_dly);
                    bus.bus_respcyc = 1'b1;
                    #1;
                    n_chk++;
                    if (bus.bus_reqcyc !== 1'b1 || bus.bus_req !== wd[bb] ||
                        d_wbeat_ack !== (k == ack_dly) || bus.bus_respack !== 1'b0 ||
                        d_done !== 1'b0 || d_rvalid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wdata_beat%0d: reqcyc=%b req=%h wbeat_ack=%b respack=%b required 1 %h %b 0",
                                 bb, bus.bus_reqcyc, bus.bus_req, d_wbeat_ack, bus.bus_respack,
                                 wd[bb], (k == ack_dly));
                    end
                    @(negedge clk);
                end
            end
            bus.bus_reqack = 0;
        end else begin
            while (b < 8 && guard < 64) begin
                guard++;
                if (b == stall_beat && stalled < stall_len) begin
                    bus.bus_respcyc = 1'b0;
                    #1;
                    n_chk++;
                    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || bus.bus_respack !== 1'b0) begin
                        n_fail++;
                        $display("FAIL resp_stall: i_rvalid=%b d_rvalid=%b respack=%b required 0 0 0",
                                 i_rvalid, d_rvalid, bus.bus_respack);
                    end
                    stalled++;
                    @(negedge clk);
                end else if (b == bad_beat && !bad_seen) begin
                    bus.bus_respcyc = 1'b1;
                    bus.bus_resptag = MEM_WRITE;
                    bus.bus_resp    = {$urandom, $urandom};
                    #1;
                    n_chk++;
                    if (bus.bus_respack !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bad_tag: respack=%b i_rvalid=%b d_rvalid=%b required 1 0 0",
                                 bus.bus_respack, i_rvalid, d_rvalid);
                    end
                    bad_seen = 1;
                    @(negedge clk);
                end else begin
                    rd = {$urandom, $urandom};
                    bus.bus_respcyc = 1'b1;
                    bus.bus_resptag = MEM_READ;
                    bus.bus_resp    = rd;
                    #1;
                    n_chk++;
                    if (exp_d ? (d_rvalid !== 1'b1 || d_rdata !== rd || d_rbeat !== 3'(b) || i_rvalid !== 1'b0)
                              : (i_rvalid !== 1'b1 || i_rdata !== rd || i_rbeat !== 3'(b) || d_rvalid !== 1'b0)) begin
                        n_fail++;
                        $display("FAIL resp_beat%0d: i_rvalid=%b i_rbeat=%0d i_rdata=%h d_rvalid=%b d_rbeat=%0d d_rdata=%h required owner_d=%b data=%h",
                                 b, i_rvalid, i_rbeat, i_rdata, d_rvalid, d_rbeat, d_rdata, exp_d, rd);
                    end
                    n_chk++;
                    if (bus.bus_respack !== 1'b1 || bus.bus_reqcyc !== 1'b0 || bus.bus_req !== '0 ||
                        d_wbeat_ack !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL resp_side%0d: respack=%b reqcyc=%b req=%h wbeat_ack=%b done=%b%b required 1 0 0 0 00",
                                 b, bus.bus_respack, bus.bus_reqcyc, bus.bus_req, d_wbeat_ack, i_done, d_done);
                    end
                    b++;
                    @(negedge clk);
                    if (b == abort_after) return;
                end
            end
            n_chk++;
            if (b != 8) begin
                n_fail++;
                $display("FAIL resp_timeout: beats=%0d required 8", b);
            end
        end
        bus.bus_respcyc = 1'b0;
        bus.bus_resptag = '0;
        #1;
        n_chk++;
        if (i_done !== (exp_d ? 1'b0 : 1'b1) || d_done !== (exp_d ? 1'b1 : 1'b0) ||
            i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || bus.bus_reqcyc !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: i_done=%b d_done=%b rvalid=%b%b reqcyc=%b required owner_d=%b",
                     i_done, d_done, i_rvalid, d_rvalid, bus.bus_reqcyc, exp_d);
        end
        if (exp_d) d_req = 0; else i_req = 0;
        model_last_d = exp_d;
        @(negedge clk); #1;
        n_chk++;
        if (i_done !== 1'b0 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: i_done=%b d_done=%b required 0 0", i_done, d_done);
        end
    endtask

    // Pick the owner the round-robin rule predicts for the current requests and serve it.
    task automatic serve_next(input int unsigned ack_dly, input int unsigned stall_beat,
                              input int unsigned stall_len, input int unsigned bad_beat,
                              input bit drop_early);
        bit e;
        e = pick_d(i_req, d_req);
        serve(e, e ? d_write : 1'b0, e ? d_addr : i_addr, ack_dly, stall_beat, stall_len,
              bad_beat, 99, drop_early);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req = 1; d_req = 1; d_write = 0;
        i_addr = rnd_addr(); d_addr = rnd_addr(); d_wdata = {$urandom, $urandom};
        bus.bus_reqack = 1; bus.bus_respcyc = 1; bus.bus_resp = {$urandom, $urandom};
        bus.bus_resptag = MEM_READ;
        for (int c = 0; c < 2; c++) begin
            repeat (2) @(negedge clk);
            #1;
            n_chk++;
            if ({bus.bus_reqcyc, bus.bus_req, bus.bus_reqtag, bus.bus_respack, d_wbeat_ack,
                 i_rvalid, d_rvalid, i_rdata, d_rdata, i_rbeat, d_rbeat, i_done, d_done} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: reqcyc=%b respack=%b rvalid=%b%b done=%b%b wbeat_ack=%b required all 0",
                         bus.bus_reqcyc, bus.bus_respack, i_rvalid, d_rvalid, i_done, d_done, d_wbeat_ack);
            end
        end
        i_req = 0; d_req = 0;
        bus.bus_reqack = 0; bus.bus_respcyc = 0; bus.bus_resptag = '0;
        reset = 1'b1;
        model_last_d = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if (bus.bus_reqcyc !== 1'b0 || bus.bus_respack !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: reqcyc=%b respack=%b done=%b%b required 0 0 00",
                     bus.bus_reqcyc, bus.bus_respack, i_done, d_done);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_addr = 64'h3000; d_addr = 64'h4000; d_write = 0;
        i_req = 1; d_req = 1;
        serve_next(0, 99, 0, 99, 0);
        i_addr = 64'h5000; i_req = 1;
        serve_next(1, 99, 0, 99, 0);
        serve_next(0, 99, 0, 99, 0);
    endtask

    task automatic test_i_read();
        i_addr = 64'h1000; i_req = 1; d_req = 0;
        serve(1'b0, 1'b0, 64'h1000, 2, 99, 0, 99, 99, 0);
    endtask

    task automatic test_writeback();
        d_addr = 64'h2040; d_write = 1; fill_wdata();
        d_req = 1; i_req = 0;
        serve(1'b1, 1'b1, 64'h2040, 2, 99, 0, 99, 99, 0);
    endtask

    task automatic test_resp_stall();
        i_addr = 64'h7fc0; i_req = 1;
        serve(1'b0, 1'b0, 64'h7fc0, 0, 4, 5, 99, 99, 0);
    endtask

    task automatic test_bad_tag();
        i_addr = 64'h8000; i_req = 1;
        serve(1'b0, 1'b0, 64'h8000, 1, 99, 0, 5, 99, 0);
    endtask

    task automatic test_reset_mid();
        d_addr = 64'h9040; d_write = 0; d_req = 1; i_req = 0;
        serve(1'b1, 1'b0, 64'h9040, 0, 99, 0, 99, 3, 0);
        reset = 1'b0; d_req = 0;
        @(negedge clk); #1;
        n_chk++;
        if ({bus.bus_reqcyc, bus.bus_req, bus.bus_reqtag, bus.bus_respack, d_wbeat_ack,
             i_rvalid, d_rvalid, i_rdata, d_rdata, i_rbeat, d_rbeat, i_done, d_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: respack=%b d_rvalid=%b d_done=%b reqcyc=%b required all 0",
                     bus.bus_respack, d_rvalid, d_done, bus.bus_reqcyc);
        end
        reset = 1'b1;
        model_last_d = 1'b1;
        bus.bus_respcyc = 0; bus.bus_resptag = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if (d_done !== 1'b0 || bus.bus_reqcyc !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet: d_done=%b reqcyc=%b required 0 0", d_done, bus.bus_reqcyc);
            end
        end
        i_addr = 64'hA000; i_req = 1;
        serve_next(0, 99, 0, 99, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_addr = rnd_addr(); i_req = 1;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_addr = rnd_addr(); d_write = 1'($urandom); fill_wdata(); d_req = 1;
            end
            if (!i_req && !d_req) begin
                i_addr = rnd_addr(); i_req = 1;
            end
            serve_next($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                       $urandom_range(0, 10), $urandom_range(0, 3) == 0);
        end
        i_req = 0; d_req = 0;
    endtask

    initial begin
        bus.bus_reqack = 0; bus.bus_respcyc = 0; bus.bus_resp = '0; bus.bus_resptag = '0;
        test_reset();
        test_round_robin();
        test_i_read();
        test_writeback();
        test_resp_stall();
        test_bad_tag();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
